// File: rtl/playfield_pkg.sv
// Shared types and constants for the tug-of-war playfield.
package playfield_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    WIN_L = 2'd1,
    WIN_R = 2'd2
  } state_t;

  localparam logic [1:0] W_NONE  = 2'b00;
  localparam logic [1:0] W_LEFT  = 2'b10;
  localparam logic [1:0] W_RIGHT = 2'b01;

endpackage

// File: rtl/playfield_sat_counter.sv
// Saturating up-counter used for the per-player round scores.
module sat_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/playfield.sv
// Tug-of-war playfield: moves a lit LED toward the pressing player,
// detects wins at either end, holds the winner display, then recentres.
module playfield
  import playfield_pkg::*;
#(
  parameter int N_LIGHTS    = 9,
  parameter int HOLD_CYCLES = 8,
  parameter int SCORE_W     = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                l_press,
  input  logic                r_press,
  output logic [N_LIGHTS-1:0] leds,
  output logic [1:0]          winner,
  output logic [SCORE_W-1:0]  score_l,
  output logic [SCORE_W-1:0]  score_r
);

  localparam int PW = $clog2(N_LIGHTS);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [PW-1:0] POS_MAX   = PW'(N_LIGHTS - 1);
  localparam logic [PW-1:0] CENTRE    = PW'(N_LIGHTS / 2);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  state_t          state;
  logic [PW-1:0]   pos;
  logic [HW-1:0]   hcnt;
  logic            l_only;
  logic            r_only;
  logic            l_win;
  logic            r_win;

  assign l_only = l_press && !r_press;
  assign r_only = r_press && !l_press;
  assign l_win  = (state == PLAY) && l_only && (pos == POS_MAX);
  assign r_win  = (state == PLAY) && r_only && (pos == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PLAY;
      pos   <= CENTRE;
      hcnt  <= '0;
    end else begin
      case (state)
        PLAY: begin
          if (l_win)
            state <= WIN_L;
          else if (r_win)
            state <= WIN_R;
          else if (l_only)
            pos <= pos + 1'b1;
          else if (r_only)
            pos <= pos - 1'b1;
        end
        WIN_L, WIN_R: begin
          if (hcnt == HOLD_LAST) begin
            state <= PLAY;
            pos   <= CENTRE;
            hcnt  <= '0;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: begin
          state <= PLAY;
          pos   <= CENTRE;
          hcnt  <= '0;
        end
      endcase
    end
  end

  always_comb begin
    leds   = '0;
    winner = W_NONE;
    case (state)
      PLAY:    leds   = N_LIGHTS'(1) << pos;
      WIN_L:   winner = W_LEFT;
      WIN_R:   winner = W_RIGHT;
      default: winner = W_NONE;
    endcase
  end

  sat_counter #(.WIDTH(SCORE_W)) u_score_l (
    .clk   (clk),
    .reset (reset),
    .inc   (l_win),
    .count (score_l)
  );

  sat_counter #(.WIDTH(SCORE_W)) u_score_r (
    .clk   (clk),
    .reset (reset),
    .inc   (r_win),
    .count (score_r)
  );

endmodule

// File: tb/tb_playfield.sv
// Directed checks of the playfield: movement, simultaneous presses,
// wins, hold timing, score saturation and reset during a hold.
module tb_playfield;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       l_press = 1'b0;
  logic       r_press = 1'b0;
  logic [8:0] leds;
  logic [1:0] winner;
  logic [2:0] score_l;
  logic [2:0] score_r;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  playfield #(.N_LIGHTS(9), .HOLD_CYCLES(8), .SCORE_W(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .l_press (l_press),
    .r_press (r_press),
    .leds    (leds),
    .winner  (winner),
    .score_l (score_l),
    .score_r (score_r)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic press_l();
    l_press = 1'b1;
    tick();
    l_press = 1'b0;
  endtask

  task automatic press_r();
    r_press = 1'b1;
    tick();
    r_press = 1'b0;
  endtask

  task automatic press_both();
    l_press = 1'b1;
    r_press = 1'b1;
    tick();
    l_press = 1'b0;
    r_press = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_leds", 32'(leds), 32'h010);
    chk("rst_winner", 32'(winner), 32'h0);
    chk("rst_score_l", 32'(score_l), 32'h0);
    chk("rst_score_r", 32'(score_r), 32'h0);

    press_l();
    chk("move_left", 32'(leds), 32'h020);
    press_r();
    chk("move_right", 32'(leds), 32'h010);

    press_both();
    chk("both_centre_leds", 32'(leds), 32'h010);
    chk("both_centre_winner", 32'(winner), 32'h0);

    for (int i = 0; i < 4; i++) press_l();
    chk("left_end", 32'(leds), 32'h100);
    press_both();
    chk("both_end_leds", 32'(leds), 32'h100);
    chk("both_end_winner", 32'(winner), 32'h0);

    press_l();
    chk("win_leds", 32'(leds), 32'h000);
    chk("win_winner", 32'(winner), 32'h2);
    chk("win_score_l", 32'(score_l), 32'h1);
    for (int i = 1; i < 8; i++) begin
      press_r();
      chk("hold_winner", 32'(winner), 32'h2);
      chk("hold_leds", 32'(leds), 32'h000);
    end
    tick();
    chk("after_hold_leds", 32'(leds), 32'h010);
    chk("after_hold_winner", 32'(winner), 32'h0);
    chk("after_hold_score_l", 32'(score_l), 32'h1);

    do_reset();
    for (int w = 1; w <= 8; w++) begin
      for (int i = 0; i < 5; i++) press_l();
      chk("sat_winner", 32'(winner), 32'h2);
      chk("sat_score_l", 32'(score_l), (w < 7) ? 32'(w) : 32'd7);
      chk("sat_score_r", 32'(score_r), 32'h0);
      for (int i = 0; i < 8; i++) tick();
    end
    chk("sat_recentre", 32'(leds), 32'h010);

    do_reset();
    for (int i = 0; i < 5; i++) press_r();
    chk("rwin1_winner", 32'(winner), 32'h1);
    for (int i = 0; i < 8; i++) tick();
    for (int i = 0; i < 5; i++) press_r();
    chk("rwin2_score_r", 32'(score_r), 32'h2);
    tick();
    tick();
    chk("rwin2_hold_winner", 32'(winner), 32'h1);
    do_reset();
    chk("midhold_rst_leds", 32'(leds), 32'h010);
    chk("midhold_rst_winner", 32'(winner), 32'h0);
    chk("midhold_rst_score_r", 32'(score_r), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/playfield.md
Name: playfield

Overview:
Tug-of-war playfield: consumes the one-cycle press pulses from the two per-player key-edge stages and moves a single lit LED toward the player who pressed. Detects a win at either end, shows the winner, and scores the round. After a fixed hold it restarts play from the centre. Drives the LED bank and the score display logic directly.

Parameters:
N_LIGHTS, 9, number of field LEDs (odd, >=3); index N_LIGHTS-1 is the left end, index 0 is the right end.
HOLD_CYCLES, 8, clock cycles the winner display is held before a new round (>=1).
SCORE_W, 3, width of each per-player score counter.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
l_press  input  1  left-player pulse, one cycle per press
r_press  input  1  right-player pulse, one cycle per press
leds  output  N_LIGHTS  one-hot field light; all-zero while a winner is shown
winner  output  2  00 none, 10 left, 01 right
score_l  output  SCORE_W  left-player rounds won
score_r  output  SCORE_W  right-player rounds won

Behaviour:
- One clock; reset is synchronous and active-high, sampled on posedge clk, and overrides all other inputs.
- State machine, states PLAY, WIN_L, WIN_R. Registered position pos in 0..N_LIGHTS-1, hold counter hcnt, two score registers.
- Reset values: state=PLAY, pos=N_LIGHTS/2 (centre, 4 for default), hcnt=0, scores=0. Outputs after reset: leds=one-hot centre, winner=00, score_l=score_r=0.
- Reset asserted mid-round or mid-hold gives the reset values at the next edge.
- Outputs decode from registers only; an input pulse sampled at edge k is visible after edge k (1-cycle latency).
- In PLAY:
  - l_press & !r_press & pos<N_LIGHTS-1: pos+1.
  - r_press & !l_press & pos>0: pos-1.
  - l_press & !r_press & pos==N_LIGHTS-1: go to WIN_L; score_l increments on the same edge.
  - r_press & !l_press & pos==0: go to WIN_R; score_r increments on the same edge.
  - Both pulses in the same cycle: no move and no win, including at either end.
  - Neither pulse: hold.
- In WIN_L or WIN_R:
  - leds=0; winner=10 (WIN_L) or 01 (WIN_R).
  - l_press and r_press are ignored.
  - hcnt counts 0..HOLD_CYCLES-1. On the edge where hcnt==HOLD_CYCLES-1: state=PLAY, pos=centre, hcnt=0.
  - The winner is displayed for exactly HOLD_CYCLES cycles.
- Scores saturate at 2^SCORE_W-1 (7). A win at saturation still enters the WIN state, but the score stays 7. Scores persist across rounds and clear only on reset.
- No illegal states: any unused state encoding returns to PLAY at the centre position.

Decomposition:
- Package playfield_pkg holds:
  - enum state_t {PLAY, WIN_L, WIN_R};
  - winner code constants W_NONE=2'b00, W_LEFT=2'b10, W_RIGHT=2'b01.
- Sub-module sat_counter, instantiated twice (one per score):
  - parameters: WIDTH;
  - ports: clk, reset, inc, count;
  - behaviour: synchronous clear on reset, increments on inc, saturates at all-ones.

Test Plan:
- Reset for 1 cycle -> leds=9'b000010000, winner=00, score_l=score_r=0.
- One l_press pulse -> next cycle leds=9'b000100000; then one r_press pulse -> leds=9'b000010000.
- l_press and r_press high in the same cycle, from centre and from pos=8 -> leds unchanged, winner=00.
- Five l_press pulses from centre:
  - after the 4th, leds=9'b100000000;
  - after the 5th, leds=0, winner=10, score_l=1;
  - r_press pulses during the hold are ignored;
  - exactly 8 cycles later, leds=9'b000010000 and winner=00.
- Eight consecutive left wins -> score_l reads 1..7, then stays 7 on the 8th win while winner=10 is still shown; score_r=0 throughout.
- Assert reset in the 3rd cycle of a WIN_R hold with score_r=2 -> next cycle leds=9'b000010000, winner=00, score_r=0.
